// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : stream bytes per 32-bit instruction word
//   IDX_W          : width of the byte-within-word index
//   csum_step      : one step of the XOR-8 frame checksum
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CSUM,
        FIN
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = 2;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: shifts accepted bytes MSB-first into a 32-bit word and
// pulses word_valid the cycle after the fourth byte of a word arrives.
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   clear            : restart at byte 0 of a word (frame start)
//   byte_valid       : a data byte is accepted this cycle
//   byte_data        : the accepted byte
//   word             : assembled word (holds the completed word while word_valid)
//   word_valid       : one-cycle pulse, word holds a complete instruction
//   last             : the next accepted byte completes a word
module imem_loader_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last
);

    logic [IDX_W-1:0] idx;

    assign last = (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx <= '0;
            end else if (byte_valid) begin
                word       <= {word[23:0], byte_data};
                idx        <= idx + IDX_W'(1);   // wraps after the fourth byte
                word_valid <= last;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory.
// Frame: count N, 4N data bytes (MSB first per word), XOR-8 checksum byte.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   start               : one-cycle pulse, begins a frame when idle
//   in_valid/in_data    : byte source
//   in_ready            : loader accepts a byte this cycle (state decode only)
//   mem_we/addr/wdata   : instruction-memory write port, one strobe per word
//   busy                : frame in progress (CPU hold)
//   done                : one-cycle pulse, frame loaded with good checksum
//   err                 : sticky error, cleared by the next accepted start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [7:0]        n_words;
    logic [7:0]        word_cnt;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              word_last;

    assign accept   = in_valid && in_ready;
    assign mem_addr = addr;

    imem_loader_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      ((state == IDLE) && start),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (in_data),
        .word       (mem_wdata),
        .word_valid (mem_we),
        .last       (word_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr     <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            csum     <= '0;
        end else begin
            done <= 1'b0;
            // Address advances after each write strobe; the frame-start
            // clear below takes priority.
            if (mem_we) begin
                addr <= addr + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COUNT;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        addr     <= '0;
                        csum     <= '0;
                        word_cnt <= '0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (in_data == 8'd0 || {1'b0, in_data} > 9'(DEPTH)) begin
                            err      <= 1'b1;
                            state    <= IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            n_words <= in_data;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum_step(csum, in_data);
                        if (word_last) begin
                            word_cnt <= word_cnt + 8'd1;
                            // CSUM is entered in the same cycle the last word is written.
                            if (word_cnt + 8'd1 == n_words) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level model turns each byte
// frame into the list of memory writes and the done/err outcome; a monitor
// checks every write strobe against that list.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;
    int done_cnt;
    wr_t exp_q[$];

    imem_loader #(.DEPTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Frame-level model: writes for every complete word present, outcome
    // decided by the count range and the XOR of the data bytes.
    function automatic void model(input bq_t f, output wr_t wq[$], output bit d, output bit e);
        int n;
        logic [7:0] cs;
        wq = {};
        d  = 1'b0;
        e  = 1'b0;
        n  = int'(f[0]);
        if (n == 0 || n > 32) begin
            e = 1'b1;
            return;
        end
        cs = 8'h00;
        for (int w = 0; w < n; w++) begin
            wr_t x;
            if (4 * w + 4 >= f.size()) break;
            x.addr = 5'(w);
            x.data = {f[4*w+1], f[4*w+2], f[4*w+3], f[4*w+4]};
            wq.push_back(x);
            cs = cs ^ f[4*w+1] ^ f[4*w+2] ^ f[4*w+3] ^ f[4*w+4];
        end
        if (f.size() > 4 * n + 1) begin
            d = (f[4*n+1] == cs);
            e = !d;
        end
    endfunction

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t x;
                x = exp_q.pop_front();
                chk("write_addr", {27'd0, mem_addr}, {27'd0, x.addr});
                chk("write_data", mem_wdata, x.data);
            end
        end
        if (done) done_cnt++;
        if (in_ready) chk("ready_implies_busy", {31'd0, busy}, 32'd1);
    end

    task automatic send_frame(input bq_t f, input int gapmax, input int start_at, input bit end_checks);
        wr_t wq[$];
        bit d, e, acc, rdy;
        int n, done0;
        model(f, wq, d, e);
        foreach (wq[k]) exp_q.push_back(wq[k]);
        n = int'(f[0]);
        done0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        chk("start_err_clear", {31'd0, err}, 32'd0);
        for (int i = 0; i < f.size(); i++) begin
            if (gapmax > 0) begin
                int g;
                g = $urandom_range(0, gapmax);
                in_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_data  = f[i];
            if (i == start_at) start = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk); #1;
                acc = rdy;
            end
            start = 1'b0;
            if (!acc) begin
                chk("byte_accept_timeout", 32'(i), 32'hFFFF_FFFF);
                break;
            end
            if (n >= 1 && n <= 32 && i >= 4 && i <= 4 * n && i % 4 == 0)
                chk("write_timing", {31'd0, mem_we}, 32'd1);
            if (i == f.size() - 1)
                chk("done_timing", {31'd0, done}, {31'd0, d});
        end
        in_valid = 1'b0;
        if (end_checks) begin
            repeat (2) begin @(posedge clk); #1; end
            chk("frame_err", {31'd0, err}, {31'd0, e});
            chk("frame_busy", {31'd0, busy}, 32'd0);
            chk("frame_done_count", 32'(done_cnt - done0), {31'd0, d});
            chk("writes_pending", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t nom, badcs, one, big, part, f;
        wr_t wq[$];
        bit d, e;
        logic [7:0] cs;

        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        nom   = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04, 8'h8E};
        badcs = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04, 8'h8F};
        one   = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        part  = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22};

        // Hand-computed pins on the model itself.
        model(nom, wq, d, e);
        chk("model_w0", wq[0].data, 32'h2001_0005);
        chk("model_w1", wq[1].data, 32'h8C22_0004);
        chk("model_a1", {27'd0, wq[1].addr}, 32'd1);
        chk("model_nom_done", {31'd0, d}, 32'd1);
        model(badcs, wq, d, e);
        chk("model_badcs_err", {31'd0, e}, 32'd1);
        model(one, wq, d, e);
        chk("model_one_done", {31'd0, d}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b1;

        // Idle: in_ready stays low with a byte waiting.
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        send_frame(nom,   0, -1, 1'b1);
        send_frame(badcs, 0, -1, 1'b1);
        send_frame(nom,   0, -1, 1'b1);   // start clears err
        send_frame('{8'h00}, 0, -1, 1'b1);
        send_frame('{8'h21}, 0, -1, 1'b1);
        send_frame(one,   0, -1, 1'b1);
        send_frame(nom,   3, -1, 1'b1);   // random in_valid gaps
        send_frame(nom,   0,  3, 1'b1);   // start pulse while busy

        // Largest legal frame: 32 words, last write at address 31.
        big = '{8'd32};
        cs  = 8'h00;
        for (int i = 0; i < 128; i++) begin
            big.push_back(8'(i * 7 + 3));
            cs = cs ^ 8'(i * 7 + 3);
        end
        big.push_back(cs);
        send_frame(big, 0, -1, 1'b1);

        // Reset after six data bytes: only word 0 is written.
        send_frame(part, 0, -1, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk_reset_vals("midreset");
        repeat (2) begin @(posedge clk); #1; end
        chk("midreset_writes_pending", 32'(exp_q.size()), 32'd0);
        send_frame(nom, 0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
